// File: rtl/psum_streamer.sv
// psum_streamer: buffers one 16-row tile of 16x24-bit accumulator partial sums,
// then streams it to the PPU as a 16-beat burst with the tile's scale/bias and
// waits for the PPU completion pulse before taking the next tile.
// Optional WAIT watchdog enabled by defining PSUM_TIMEOUT_EN.
module psum_streamer #(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         acc_valid,
   output logic         acc_ready,
   input  logic [383:0] acc_data,
   input  logic         acc_last,
   input  logic [7:0]   scale_in,
   input  logic [7:0]   bias_in,
   output logic [383:0] partial_sum,
   output logic [7:0]   scale,
   output logic [7:0]   bias,
   output logic         valid,
   input  logic         ppu_done,
   output logic         tile_done,
   output logic         short_tile,
   output logic [7:0]   tile_count,
   output logic         timeout
);

   localparam int RW = 384;
   localparam int PW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_WAIT = 2'd3;

   // The PPU burst length is hard-wired to 16 beats; reject other builds early.
   if (DEPTH != 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("psum_streamer: DEPTH must be 16 and TIMEOUT_CYCLES >= 1");
   end

   logic [1:0]             state_q, state_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [7:0]             scale_q, scale_d;
   logic [7:0]             bias_q, bias_d;
   logic                   tile_done_q, tile_done_d;
   logic                   short_q, short_d;
   logic [7:0]             tile_cnt_q, tile_cnt_d;
   logic [DEPTH-1:0][RW-1:0] buf_q;

   logic          accept;
   logic [PW-1:0] wr_idx;
   logic          at_end;
   logic          close_evt;
   logic          short_evt;
   logic          wd_expire;

   // Upstream is held off while the tile is being sent or the PPU is busy,
   // and during reset.
   assign acc_ready = !rst && (state_q == S_IDLE || state_q == S_FILL);
   assign accept    = acc_valid && acc_ready;

   // The first row of a tile always lands in slot 0.
   assign wr_idx    = (state_q == S_IDLE) ? '0 : wr_ptr_q;
   assign at_end    = (wr_idx == PW'(DEPTH - 1));
   assign close_evt = accept && (at_end || acc_last);
   assign short_evt = accept && acc_last && !at_end;

`ifdef PSUM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] wd_cnt_q;
   logic          timeout_q;

   // Fires on the last allowed WAIT cycle; a same-cycle ppu_done still wins.
   assign wd_expire = (state_q == S_WAIT) && !ppu_done &&
                      (wd_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   // Watchdog counts consecutive WAIT cycles; timeout flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == S_WAIT && !ppu_done && !wd_expire)
            wd_cnt_q <= wd_cnt_q + TW'(1);
         else
            wd_cnt_q <= '0;
         if (wd_expire)
            timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   assign wd_expire = 1'b0;
   assign timeout   = 1'b0;
`endif

   // Row storage: write the accepted row and, on a short tile, clear every
   // later slot in the same cycle so the burst can start immediately.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (PW'(i) == wr_idx)
               buf_q[i] <= acc_data;
            else if (short_evt && (PW'(i) > wr_idx))
               buf_q[i] <= '0;
         end
      end
   end

   // Tile sequencing: IDLE -> FILL -> SEND (16 beats) -> WAIT -> IDLE.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      scale_d     = scale_q;
      bias_d      = bias_q;
      tile_done_d = 1'b0;
      short_d     = 1'b0;
      tile_cnt_d  = tile_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               scale_d  = scale_in;
               bias_d   = bias_in;
               short_d  = short_evt;
               if (close_evt) begin
                  wr_ptr_d = '0;
                  state_d  = S_SEND;
               end else begin
                  wr_ptr_d = PW'(1);
                  state_d  = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (accept) begin
               short_d = short_evt;
               if (close_evt) begin
                  wr_ptr_d = '0;
                  state_d  = S_SEND;
               end else begin
                  wr_ptr_d = wr_ptr_q + PW'(1);
               end
            end
         end
         S_SEND: begin
            if (rd_ptr_q == PW'(DEPTH - 1)) begin
               rd_ptr_d = '0;
               state_d  = S_WAIT;
            end else begin
               rd_ptr_d = rd_ptr_q + PW'(1);
            end
         end
         default: begin
            if (ppu_done) begin
               state_d     = S_IDLE;
               tile_done_d = 1'b1;
               tile_cnt_d  = tile_cnt_q + 8'd1;
            end else if (wd_expire) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // Control state register with synchronous reset; a reset mid-tile drops
   // the tile entirely.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         scale_q     <= '0;
         bias_q      <= '0;
         tile_done_q <= 1'b0;
         short_q     <= 1'b0;
         tile_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         scale_q     <= scale_d;
         bias_q      <= bias_d;
         tile_done_q <= tile_done_d;
         short_q     <= short_d;
         tile_cnt_q  <= tile_cnt_d;
      end
   end

   assign valid       = (state_q == S_SEND);
   assign partial_sum = valid ? buf_q[rd_ptr_q] : '0;
   assign scale       = scale_q;
   assign bias        = bias_q;
   assign tile_done   = tile_done_q;
   assign short_tile  = short_q;
   assign tile_count  = tile_cnt_q;

endmodule

// File: tb/tb_psum_streamer.sv
// Scoreboard bench for psum_streamer: every tile built by the stimulus pushes
// its 16 expected beats (rows padded with zero rows) plus scale/bias; a
// negedge monitor pops and compares whenever valid is high.
module tb_psum_streamer;

   logic         clk = 1'b0;
   logic         rst;
   logic         acc_valid;
   logic         acc_ready;
   logic [383:0] acc_data;
   logic         acc_last;
   logic [7:0]   scale_in;
   logic [7:0]   bias_in;
   logic [383:0] partial_sum;
   logic [7:0]   scale;
   logic [7:0]   bias;
   logic         valid;
   logic         ppu_done;
   logic         tile_done;
   logic         short_tile;
   logic [7:0]   tile_count;
   logic         timeout;

   always #5 clk = ~clk;

   psum_streamer dut (
      .clk(clk), .rst(rst),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
      .acc_last(acc_last), .scale_in(scale_in), .bias_in(bias_in),
      .partial_sum(partial_sum), .scale(scale), .bias(bias), .valid(valid),
      .ppu_done(ppu_done), .tile_done(tile_done), .short_tile(short_tile),
      .tile_count(tile_count), .timeout(timeout)
   );

   typedef struct {
      logic [383:0] d;
      logic [7:0]   sc;
      logic [7:0]   bi;
   } beat_t;

   beat_t        exp_q[$];
   int           total = 0;
   int           bad   = 0;
   logic [383:0] rows[16];
   logic [7:0]   tsc;
   logic [7:0]   tbi;
   int           exp_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic chkw(input string nm, input logic [383:0] act, input logic [383:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a tile of n rows is streamed as those rows followed by
   // zero rows up to 16, all tagged with the scale/bias of its first row.
   task automatic build_tile(input int n, input bit pat);
      beat_t b;
      for (int r = 0; r < 16; r++) begin
         if (r < n) begin
            if (pat) begin
               for (int j = 0; j < 16; j++) rows[r][24*j +: 24] = 24'(r*16 + j);
            end else begin
               for (int k = 0; k < 12; k++) rows[r][32*k +: 32] = $urandom;
            end
         end
         b.d  = (r < n) ? rows[r] : '0;
         b.sc = tsc;
         b.bi = tbi;
         exp_q.push_back(b);
      end
   endtask

   // Offer rows r0..n-1 with occasional bubbles; acc_last marks a short tile.
   task automatic drive_rows(input int r0, input int n);
      int g;
      for (int r = r0; r < n; r++) begin
         if (r > r0 && $urandom_range(0, 3) == 0) begin
            acc_valid = 1'b0;
            tick();
         end
         acc_valid = 1'b1;
         acc_data  = rows[r];
         acc_last  = (r == n - 1) && (n < 16);
         scale_in  = (r == 0) ? tsc : 8'($urandom);
         bias_in   = (r == 0) ? tbi : 8'($urandom);
         g = 0;
         while (acc_ready !== 1'b1 && g < 100) begin
            tick();
            g++;
         end
         if (g >= 100) chk("ready_wait_timeout", 32'(g), 32'(0));
         tick();
      end
      acc_valid = 1'b0;
      acc_last  = 1'b0;
      acc_data  = '0;
      chk("burst_start", 32'(valid), 32'(1));
      chk("short_tile", 32'(short_tile), 32'(n < 16));
   endtask

   // Follow the burst from beat 0 to its end; pokes ppu_done mid-burst, which
   // must be ignored.
   task automatic wait_burst(input bit hold);
      int g;
      g = 0;
      while (valid === 1'b1 && g < 40) begin
         ppu_done = (g == 3);
         if (g == 1) chk("short_pulse_len", 32'(short_tile), 32'(0));
         if (hold) chk("ready_send", 32'(acc_ready), 32'(0));
         tick();
         g++;
      end
      ppu_done = 1'b0;
      chk("burst_len", 32'(g), 32'(16));
      chk("sb_drained", 32'(exp_q.size()), hold ? 32'(16) : 32'(0));
   endtask

   // PPU latency in WAIT, then a completion pulse.
   task automatic complete_tile(input int lat);
      repeat (lat) begin
         chk("ready_wait", 32'(acc_ready), 32'(0));
         tick();
      end
      ppu_done = 1'b1;
      tick();
      ppu_done = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      chk("tile_done", 32'(tile_done), 32'(1));
      chk("tile_count", 32'(tile_count), 32'(exp_cnt));
      chk("ready_idle", 32'(acc_ready), 32'(1));
      tick();
      chk("tile_done_len", 32'(tile_done), 32'(0));
   endtask

   task automatic finish_tile(input bit hold, input int lat);
      wait_burst(hold);
      complete_tile(lat);
   endtask

   // Monitor: compare each presented beat against the scoreboard head.
   always @(negedge clk) begin : mon
      beat_t e;
      if (valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got %0h want no beat", partial_sum);
         end else begin
            e = exp_q.pop_front();
            chkw("beat_data", partial_sum, e.d);
            chk("beat_scale", 32'(scale), 32'(e.sc));
            chk("beat_bias", 32'(bias), 32'(e.bi));
         end
      end else begin
         chkw("idle_zero", partial_sum, '0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; acc_valid = 1'b0; acc_data = '0; acc_last = 1'b0;
      scale_in = '0; bias_in = '0; ppu_done = 1'b0;
      repeat (3) tick();
      chk("rst_ready", 32'(acc_ready), 32'(0));
      chk("rst_valid", 32'(valid), 32'(0));
      chkw("rst_psum", partial_sum, '0);
      chk("rst_scale", 32'(scale), 32'(0));
      chk("rst_bias", 32'(bias), 32'(0));
      chk("rst_tile_done", 32'(tile_done), 32'(0));
      chk("rst_short", 32'(short_tile), 32'(0));
      chk("rst_count", 32'(tile_count), 32'(0));
      chk("rst_timeout", 32'(timeout), 32'(0));
      rst = 1'b0;
      tick();

      // Full ramp tile; later rows carry different scale/bias that must not leak.
      tsc = 8'h38; tbi = 8'h05;
      build_tile(16, 1'b1);
      drive_rows(0, 16);
      finish_tile(1'b0, 2);
      chk("count_after_first", 32'(tile_count), 32'(1));

      // acc_last on row 5: rows 6..15 become zeros, burst still 16 beats.
      tsc = 8'($urandom); tbi = 8'($urandom);
      build_tile(6, 1'b0);
      drive_rows(0, 6);
      finish_tile(1'b0, 1);

      // Next tile's first row held on the bus through SEND and WAIT.
      tsc = 8'($urandom); tbi = 8'($urandom);
      build_tile(16, 1'b0);
      drive_rows(0, 16);
      tsc = 8'($urandom); tbi = 8'($urandom);
      build_tile(16, 1'b0);
      acc_valid = 1'b1; acc_data = rows[0]; acc_last = 1'b0;
      scale_in = tsc; bias_in = tbi;
      finish_tile(1'b1, 3);
      drive_rows(1, 16);
      finish_tile(1'b0, 0);

      // Random tile lengths, contents and PPU latencies.
      repeat (20) begin
         n = $urandom_range(1, 16);
         tsc = 8'($urandom); tbi = 8'($urandom);
         build_tile(n, 1'b0);
         drive_rows(0, n);
         finish_tile(1'b0, $urandom_range(0, 4));
      end

      // Reset in the middle of a burst (beat 7).
      tsc = 8'($urandom); tbi = 8'($urandom);
      build_tile(16, 1'b0);
      drive_rows(0, 16);
      repeat (7) tick();
      chk("beat7_valid", 32'(valid), 32'(1));
      rst = 1'b1;
      tick();
      chk("midrst_valid", 32'(valid), 32'(0));
      chk("midrst_count", 32'(tile_count), 32'(0));
      chkw("midrst_psum", partial_sum, '0);
      chk("midrst_ready", 32'(acc_ready), 32'(0));
      chk("midrst_scale", 32'(scale), 32'(0));
      exp_q.delete();
      exp_cnt = 0;
      tick();
      rst = 1'b0;
      repeat (20) begin
         chk("no_resume", 32'(valid), 32'(0));
         tick();
      end

      // 256 one-row tiles: tile_count passes 255 and wraps back to 0.
      for (int t = 0; t < 256; t++) begin
         tsc = 8'($urandom); tbi = 8'($urandom);
         build_tile(1, 1'b0);
         drive_rows(0, 1);
         finish_tile(1'b0, 0);
      end
      chk("wrap_count", 32'(tile_count), 32'(0));

      tsc = 8'($urandom); tbi = 8'($urandom);
      build_tile(3, 1'b0);
      drive_rows(0, 3);
      wait_burst(1'b0);
`ifdef PSUM_TIMEOUT_EN
      // First WAIT cycle observed; 254 more still in WAIT, then watchdog fires.
      repeat (254) tick();
      chk("wd_early_ready", 32'(acc_ready), 32'(0));
      chk("wd_early_flag", 32'(timeout), 32'(0));
      tick();
      chk("wd_flag", 32'(timeout), 32'(1));
      chk("wd_idle", 32'(acc_ready), 32'(1));
      chk("wd_count", 32'(tile_count), 32'(exp_cnt));
      chk("wd_no_done", 32'(tile_done), 32'(0));
      tsc = 8'($urandom); tbi = 8'($urandom);
      build_tile(16, 1'b0);
      drive_rows(0, 16);
      finish_tile(1'b0, 1);
      chk("wd_sticky", 32'(timeout), 32'(1));
`else
      repeat (300) tick();
      chk("wait_forever", 32'(acc_ready), 32'(0));
      chk("no_timeout", 32'(timeout), 32'(0));
      complete_tile(0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
